add64_seq: RTL and testbench
============================

ADD64_SEQ -- requirements
Module: add64_seq

Interface
REQ-001 Parameter: NSLICE, default 4, number of 16-bit slices; operand width W = 16*NSLICE.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 a64  input  W  operand A, captured on start acceptance.
REQ-006 b64  input  W  operand B, captured on start acceptance.
REQ-007 cin  input  1  carry-in to slice 0, captured on start acceptance.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum64  output  W  registered result, modulo 2^W.
REQ-011 cout  output  1  registered carry out of slice NSLICE-1.

Function
REQ-012 The block SHALL contain exactly one add16_cla instance, reused every RUN cycle for one 16-bit slice.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding is implementation choice.
REQ-014 IDLE: start=1 SHALL capture a64, b64, cin into operand registers, clear slice index to 0, go RUN; start=0 stays IDLE.
REQ-015 RUN: each cycle slice k SHALL add A[16k+15:16k] + B[16k+15:16k] + carry reg, write slice sum to internal accumulator, store slice carry-out into carry reg, increment k.
REQ-016 RUN with k = NSLICE-1 SHALL go DONE next cycle; carry reg for slice 0 SHALL be the captured cin.
REQ-017 Entry into DONE SHALL load sum64 and cout from accumulator/carry reg and assert done for exactly that one cycle; DONE SHALL return to IDLE unconditionally.
REQ-018 Latency: start accepted at edge T SHALL give done=1 in the cycle after edge T+NSLICE+1 (5 edges after acceptance for NSLICE=4); throughput one result per NSLICE+2 cycles.
REQ-019 sum64 and cout SHALL hold last result stable from done until the next result load; partial sums SHALL never appear on sum64.
REQ-020 start in RUN or DONE SHALL be ignored, no queueing; operand input changes after acceptance SHALL not affect the result.
REQ-021 Overflow SHALL wrap: sum64 = (A+B+cin) mod 2^W, cout = bit W of the full sum.

Reset
REQ-022 reset=1 at an edge SHALL force IDLE, k=0, busy=0, done=0, sum64=0, cout=0, operand and carry registers 0.
REQ-023 reset SHALL take priority over start and over any state; reset mid-RUN aborts with no done pulse.
REQ-024 First start accepted SHALL be the one sampled at the first edge with reset=0.

Configuration
REQ-025 Macro ADD64_SEQ_SUB_EN defined: extra input port sub (1 bit, after cin), captured with operands; sub=1 SHALL store ~b64 and force slice-0 carry to 1 (cin ignored), giving A-B mod 2^W, cout=1 meaning no borrow.
REQ-026 Macro ADD64_SEQ_SUB_EN undefined: sub port absent, addition only, behaviour per REQ-012..REQ-021.

Verification (NSLICE=4)
REQ-027 a64=0x0000_0000_0000_FFFF, b64=1, cin=0, start one cycle -> sum64=0x0000_0000_0001_0000, cout=0, done exactly 5 edges after acceptance, busy high 5 cycles.
REQ-028 a64=0xFFFF_FFFF_FFFF_FFFF, b64=0, cin=1 -> sum64=0, cout=1 (carry rippled through all four slices).
REQ-029 a64=0xCCCC_CCCC_CCCC_CCCC, b64=0xC564_C564_C564_C564, cin=0 -> sum64=0x9231_9231_9231_9230, cout=1.
REQ-030 start re-pulsed with a64=b64=0x1234 during RUN k=2 -> ignored; result equals first operation; no second done.
REQ-031 reset pulsed during RUN k=1 -> next cycle busy=0, done=0, sum64=0, cout=0; subsequent start with a64=2, b64=3 yields sum64=5, done once.
REQ-032 With ADD64_SEQ_SUB_EN: a64=5, b64=7, sub=1 -> sum64=0xFFFF_FFFF_FFFF_FFFE, cout=0; a64=7, b64=5, sub=1 -> sum64=2, cout=1.

Source files
------------

// File: rtl/add64_seq.sv
// Multi-cycle W-bit adder that reuses one 16-bit CLA slice per cycle.
// Optional subtract mode (sub port) is enabled by defining ADD64_SEQ_SUB_EN.

module add16_cla (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    logic [15:0] p, g, c;
    logic [3:0]  gp, gg;
    logic [4:0]  gc;

    always_comb begin
        p     = a ^ b;
        g     = a & b;
        gp    = '0;
        gg    = '0;
        gc    = '0;
        c     = '0;
        gc[0] = ci;
        // Group-level lookahead across four 4-bit groups, then in-group carries.
        for (int unsigned j = 0; j < 4; j++) begin
            gp[j]   = &p[4*j +: 4];
            gg[j]   = g[4*j+3]
                    | (p[4*j+3] & g[4*j+2])
                    | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                    | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int unsigned j = 0; j < 4; j++) begin
            c[4*j] = gc[j];
            for (int unsigned k = 1; k < 4; k++) begin
                c[4*j+k] = g[4*j+k-1] | (p[4*j+k-1] & c[4*j+k-1]);
            end
        end
        s  = p ^ c;
        co = gc[4];
    end
endmodule

module add64_seq #(
    parameter int unsigned NSLICE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [16*NSLICE-1:0] a64,
    input  logic [16*NSLICE-1:0] b64,
    input  logic                 cin,
`ifdef ADD64_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [16*NSLICE-1:0] sum64,
    output logic                 cout
);
    localparam int unsigned W  = 16 * NSLICE;
    localparam int unsigned KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic            carry_q, carry_d, cout_q, cout_d, done_q, done_d;
    logic [15:0]     a_sl, b_sl, s_sl;
    logic            co_sl;
    logic [W-1:0]    b_cap;
    logic            c_cap;

    add16_cla u_cla (
        .a  (a_sl),
        .b  (b_sl),
        .ci (carry_q),
        .s  (s_sl),
        .co (co_sl)
    );

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (k_q == KW'(i)) begin
                a_sl = a_q[16*i +: 16];
                b_sl = b_q[16*i +: 16];
            end
        end
    end

`ifdef ADD64_SEQ_SUB_EN
    assign b_cap = sub ? ~b64 : b64;
    assign c_cap = sub ? 1'b1 : cin;
`else
    assign b_cap = b64;
    assign c_cap = cin;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a64;
                    b_d     = b_cap;
                    carry_d = c_cap;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (k_q == KW'(i)) acc_d[16*i +: 16] = s_sl;
                end
                carry_d = co_sl;
                if (k_q == KW'(NSLICE - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                // Result registers change only here, so partial sums never reach sum64.
                sum_d   = acc_q;
                cout_d  = carry_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign sum64 = sum_q;
    assign cout  = cout_q;
endmodule

// File: tb/tb_add64_seq.sv
// Scoreboard bench for add64_seq (NSLICE=4); subtract cases need ADD64_SEQ_SUB_EN.

module tb_add64_seq;
    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a64 = '0;
    logic [W-1:0] b64 = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum64;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [W:0]   exp_q[$];

    add64_seq #(.NSLICE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a64   (a64),
        .b64   (b64),
        .cin   (cin),
`ifdef ADD64_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum64 (sum64),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("sum64", sum64, e[W-1:0]);
                chk("cout", cout, e[W]);
            end
        end
    end

    // mode 0: plain op; 1: re-pulse start at k=2; 2: reset at k=1
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input int mode);
        int edges;
        int busy_cnt;
        logic [W:0] full;
        a64 = a; b64 = b; cin = c; sub = s; start = 1'b1;
        if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        exp_q.push_back(full);
        @(posedge clk); #1;
        start = 1'b0;
        a64 = ~a; b64 = ~b; cin = ~c;
        edges = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && edges < 20) begin
            if (busy === 1'b1) busy_cnt++;
            if (mode == 2 && edges == 1) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_sum", sum64, 0);
                chk("abort_cout", cout, 0);
                void'(exp_q.pop_back());
                return;
            end
            if (mode == 1 && edges == 2) begin
                start = 1'b1; a64 = 64'h1234; b64 = 64'h1234;
            end
            if (mode == 1 && edges == 3) start = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", edges, 5);
        chk("busy_cycles", busy_cnt, 5);
        chk("busy_at_done", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum64, 0);
        chk("rst_cout", cout, 0);
        reset = 1'b0;

        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
        run_op(64'hCCCC_CCCC_CCCC_CCCC, 64'hC564_C564_C564_C564, 1'b0, 1'b0, 0);
        chk("hold_sum", sum64, 64'h9231_9231_9231_9230);
        run_op(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;
        run_op(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0, 2);
        run_op(64'd2, 64'd3, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 0);
        end
`ifdef ADD64_SEQ_SUB_EN
        run_op(64'd5, 64'd7, 1'b0, 1'b1, 0);
        run_op(64'd7, 64'd5, 1'b1, 1'b1, 0);
        run_op(64'd2, 64'd3, 1'b1, 1'b0, 0);
`endif
        repeat (12) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
